// File: rtl/csa_acc_ctrl_pkg.sv
// Shared definitions for the carry-save accumulator: default widths and FSM states.
package csa_acc_ctrl_pkg;

    localparam int K_DEFAULT  = 33;
    localparam int CW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE,
        HOLD
    } state_t;

endpackage

// File: rtl/csa_acc_ctrl_csa_3to2.sv
// Full-width 3:2 carry-save compressor; the carry out of the top bit is dropped.
module csa_3to2 #(
    parameter int K = 33
) (
    input  logic [K-1:0] x,
    input  logic [K-1:0] y,
    input  logic [K-1:0] z,
    output logic [K-1:0] c,
    output logic [K-1:0] s
);

    assign s = x ^ y ^ z;

    // Majority of each bit pair feeds the next bit up; bit 0 of the carry is always zero.
    assign c = {(x[K-2:0] & y[K-2:0]) | (x[K-2:0] & z[K-2:0]) | (y[K-2:0] & z[K-2:0]), 1'b0};

endmodule

// File: rtl/csa_acc_ctrl.sv
// Group accumulator: sums operands in carry-save form, resolves once per group, holds result.
module csa_acc_ctrl
    import csa_acc_ctrl_pkg::*;
#(
    parameter int K  = K_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [K-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [K-1:0]  out_data,
    output logic [CW-1:0] out_count
);

    state_t        state;
    state_t        state_next;
    logic [K-1:0]  sum_reg;
    logic [K-1:0]  carry_reg;
    logic [CW-1:0] count;
    logic [K-1:0]  csa_s;
    logic [K-1:0]  csa_c;
    logic          xfer;

    assign xfer = in_valid && in_ready;

    csa_3to2 #(.K(K)) u_csa (
        .x (sum_reg),
        .y (carry_reg),
        .z (in_data),
        .c (csa_c),
        .s (csa_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (xfer) state_next = in_last ? RESOLVE : ACCUM;
            ACCUM:   if (xfer && in_last) state_next = RESOLVE;
            RESOLVE: state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs depend on state alone, so no combinational path exists from the inputs.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            ACCUM:   in_ready  = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: the only carry-propagate add happens in RESOLVE; the count saturates at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_reg   <= '0;
            carry_reg <= '0;
            count     <= '0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        sum_reg   <= in_data;
                        carry_reg <= '0;
                        count     <= CW'(1);
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        sum_reg   <= csa_s;
                        carry_reg <= csa_c;
                        if (count != {CW{1'b1}}) begin
                            count <= count + CW'(1);
                        end
                    end
                end
                RESOLVE: begin
                    out_data  <= sum_reg + carry_reg;
                    out_count <= count;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_acc_ctrl.sv
// Self-checking bench for csa_acc_ctrl: directed and randomized groups against a plain-sum model.
module tb_csa_acc_ctrl;

    localparam int K  = 33;
    localparam int CW = 8;
    localparam int MAX_COUNT = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [K-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [K-1:0]  out_data;
    logic [CW-1:0] out_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: group sum wraps naturally in K bits, count is clamped.
    logic [K-1:0] m_sum   = '0;
    int           m_count = 0;

    csa_acc_ctrl #(.K(K), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Idle gap cycles carry random ignored data, then one operand is transferred on the next edge.
    task automatic applyStimulus(input logic [K-1:0] data, input bit last, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = K'({$urandom(), $urandom()});
            in_last  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("in_ready_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        m_sum = m_sum + data;
        if (m_count < MAX_COUNT) m_count++;
    endtask

    // Called right after the last operand's edge: one RESOLVE cycle, then HOLD for holdCycles extra cycles.
    task automatic checkOutput(input int holdCycles);
        @(negedge clk);
        chk("resolve_out_valid", 64'(out_valid), 64'd0);
        chk("resolve_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("hold_out_valid", 64'(out_valid), 64'd1);
        chk("hold_in_ready", 64'(in_ready), 64'd0);
        chk("out_data", 64'(out_data), 64'(m_sum));
        chk("out_count", 64'(out_count), 64'(m_count));
        for (int h = 0; h < holdCycles; h++) begin
            @(negedge clk);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_data", 64'(out_data), 64'(m_sum));
            chk("stall_out_count", 64'(out_count), 64'(m_count));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        m_sum   = '0;
        m_count = 0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_out_count", 64'(out_count), 64'd0);
        reset = 1'b0;

        // Single-operand group.
        applyStimulus(33'h1_2345_6789, 1'b1, 0);
        checkOutput(0);

        // Back-to-back 1..4.
        applyStimulus(33'd1, 1'b0, 0);
        applyStimulus(33'd2, 1'b0, 0);
        applyStimulus(33'd3, 1'b0, 0);
        applyStimulus(33'd4, 1'b1, 0);
        chk("model_sum_1to4", 64'(m_sum), 64'd10);
        checkOutput(0);

        // Wrap-around of the K-bit sum.
        applyStimulus(33'h1_FFFF_FFFF, 1'b0, 0);
        applyStimulus(33'h1_FFFF_FFFF, 1'b0, 1);
        applyStimulus(33'h1_FFFF_FFFF, 1'b1, 0);
        checkOutput(0);

        // Consumer stalls for five cycles.
        applyStimulus(33'h0_0F0F_0F0F, 1'b0, 0);
        applyStimulus(33'h1_F0F0_F0F0, 1'b1, 0);
        checkOutput(5);

        // Reset mid-group discards the partial sum.
        applyStimulus(33'd5, 1'b0, 0);
        applyStimulus(33'd6, 1'b0, 0);
        @(negedge clk);
        chk("midgroup_no_result", 64'(out_valid), 64'd0);
        reset = 1'b1;
        #1;
        chk("async_reset_out_valid", 64'(out_valid), 64'd0);
        chk("async_reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        m_sum   = '0;
        m_count = 0;
        applyStimulus(33'd7, 1'b0, 0);
        applyStimulus(33'd8, 1'b1, 0);
        checkOutput(0);

        // Reset while a result is pending in HOLD drops it.
        applyStimulus(33'd9, 1'b0, 0);
        applyStimulus(33'd11, 1'b1, 0);
        repeat (2) @(negedge clk);
        chk("pending_before_reset", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("hold_reset_out_valid", 64'(out_valid), 64'd0);
        chk("hold_reset_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        m_sum   = '0;
        m_count = 0;
        applyStimulus(33'h1_0000_0001, 1'b1, 0);
        checkOutput(0);

        // Randomized groups with random gaps and stalls.
        for (int grp = 0; grp < 8; grp++) begin
            automatic int n = int'($urandom_range(1, 7));
            for (int i = 0; i < n; i++) begin
                applyStimulus(K'({$urandom(), $urandom()}), (i == n - 1), int'($urandom_range(0, 2)));
            end
            checkOutput(int'($urandom_range(0, 3)));
        end

        // 300 ones with gaps: count saturates while the sum keeps going.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(33'd1, (i == 299), (i % 7 == 3) ? int'($urandom_range(1, 3)) : 0);
        end
        chk("model_sat_count", 64'(m_count), 64'd255);
        checkOutput(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
